// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used across pipeline stages.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/mem_access_ctrl_pkg.sv
// Types shared by the memory-stage access controller.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    DONE,
    FLUSH,
    HALTED
  } memctl_state_t;

  typedef enum logic {
    MEM_RD,
    MEM_WR
  } mem_op_t;

  // A request with both enables set is treated as a store.
  function automatic mem_op_t decode_op(input logic wen_i);
    return wen_i ? MEM_WR : MEM_RD;
  endfunction

endpackage : mem_access_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already all-ones.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: runs the D-cache request/hit handshake for the
// EX/MEM latch, stalls the pipeline while busy and sequences the halt flush.
module mem_access_ctrl
  import cpu_types_pkg::*;
  import mem_access_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             em_d_ren_i,
  input  logic             em_d_wen_i,
  input  word_t            em_dmemaddr_i,
  input  word_t            em_dmemstore_i,
  input  logic             em_halt_i,
  input  logic             dhit,
  input  word_t            dmemload,
  input  logic             flushed,
  output logic             dmemREN,
  output logic             dmemWEN,
  output word_t            dmemaddr,
  output word_t            dmemstore,
  output logic             cache_halt,
  output logic             mem_stall,
  output logic             mem_done,
  output word_t            load_data,
  output logic             cpu_halted,
  output logic             timeout_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] access_cnt
);

  // Watchdog is wide enough to hold MAX_WAIT; it saturates above that.
  localparam int               WD_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MAX_WAIT - 1);

  memctl_state_t   state_q;
  logic            ren_q, wen_q;
  word_t           addr_q, store_q, load_q;
  logic            done_q, proto_q, cache_halt_q, halted_q, timeout_q;
  logic            req;
  mem_op_t         req_op;
  logic [WD_W-1:0] wd_cnt;

  assign req    = em_d_ren_i | em_d_wen_i;
  assign req_op = decode_op(em_d_wen_i);

  // Watchdog: cleared when a request is accepted, counts ACCESS cycles without a hit.
  sat_counter #(.W(WD_W)) u_wd_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i ((state_q == IDLE) && req),
    .inc_i ((state_q == ACCESS) && !dhit),
    .cnt_o (wd_cnt)
  );

  // Completed-access counter, bumped once per DONE cycle.
  sat_counter #(.W(CNT_W)) u_access_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (1'b0),
    .inc_i (state_q == DONE),
    .cnt_o (access_cnt)
  );

  // Controller FSM with all handshake/status outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      store_q      <= '0;
      load_q       <= '0;
      done_q       <= 1'b0;
      proto_q      <= 1'b0;
      cache_halt_q <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      proto_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A pending access is served before a halt held in the same latch.
          if (req) begin
            addr_q  <= em_dmemaddr_i;
            store_q <= em_dmemstore_i;
            ren_q   <= (req_op == MEM_RD);
            wen_q   <= (req_op == MEM_WR);
            proto_q <= em_d_ren_i & em_d_wen_i;
            state_q <= ACCESS;
          end else if (em_halt_i) begin
            cache_halt_q <= 1'b1;
            state_q      <= FLUSH;
          end
        end
        ACCESS: begin
          if (dhit) begin
            if (ren_q) load_q <= dmemload;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (wd_cnt >= WD_LAST) begin
            // This miss brings the wait count to MAX_WAIT; keep waiting regardless.
            timeout_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        FLUSH: begin
          if (flushed) begin
            halted_q <= 1'b1;
            state_q  <= HALTED;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall is the only combinational output: it must freeze the latch in the request cycle.
  assign mem_stall = ((state_q == IDLE) && req) || (state_q == ACCESS) ||
                     (state_q == FLUSH) || (state_q == HALTED);

  assign dmemREN     = ren_q;
  assign dmemWEN     = wen_q;
  assign dmemaddr    = addr_q;
  assign dmemstore   = store_q;
  assign cache_halt  = cache_halt_q;
  assign mem_done    = done_q;
  assign load_data   = load_q;
  assign cpu_halted  = halted_q;
  assign timeout_err = timeout_q;
  assign proto_err   = proto_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized accesses
// checked against a transaction-level expectation model.
module tb_mem_access_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             em_d_ren_i, em_d_wen_i, em_halt_i;
  logic [31:0]      em_dmemaddr_i, em_dmemstore_i;
  logic             dhit, flushed;
  logic [31:0]      dmemload;
  logic             dmemREN, dmemWEN, cache_halt, mem_stall, mem_done;
  logic [31:0]      dmemaddr, dmemstore, load_data;
  logic             cpu_halted, timeout_err, proto_err;
  logic [CNT_W-1:0] access_cnt;

  int errors = 0;
  int checks = 0;

  // Expectation model state (transaction level).
  logic [31:0] exp_load;
  int          exp_cnt;
  bit          exp_to;

  mem_access_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .em_d_ren_i     (em_d_ren_i),
    .em_d_wen_i     (em_d_wen_i),
    .em_dmemaddr_i  (em_dmemaddr_i),
    .em_dmemstore_i (em_dmemstore_i),
    .em_halt_i      (em_halt_i),
    .dhit           (dhit),
    .dmemload       (dmemload),
    .flushed        (flushed),
    .dmemREN        (dmemREN),
    .dmemWEN        (dmemWEN),
    .dmemaddr       (dmemaddr),
    .dmemstore      (dmemstore),
    .cache_halt     (cache_halt),
    .mem_stall      (mem_stall),
    .mem_done       (mem_done),
    .load_data      (load_data),
    .cpu_halted     (cpu_halted),
    .timeout_err    (timeout_err),
    .proto_err      (proto_err),
    .access_cnt     (access_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_load = '0;
    exp_cnt  = 0;
    exp_to   = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ren"},     32'(dmemREN),     0);
    check({pfx, "_wen"},     32'(dmemWEN),     0);
    check({pfx, "_addr"},    dmemaddr,         0);
    check({pfx, "_store"},   dmemstore,        0);
    check({pfx, "_chalt"},   32'(cache_halt),  0);
    check({pfx, "_done"},    32'(mem_done),    0);
    check({pfx, "_load"},    load_data,        0);
    check({pfx, "_halted"},  32'(cpu_halted),  0);
    check({pfx, "_timeout"}, 32'(timeout_err), 0);
    check({pfx, "_proto"},   32'(proto_err),   0);
    check({pfx, "_cnt"},     32'(access_cnt),  0);
  endtask

  // Random values on inputs the controller must ignore in the current cycle.
  task automatic drive_garbage();
    em_d_ren_i     = 1'($urandom);
    em_d_wen_i     = 1'($urandom);
    em_halt_i      = 1'($urandom);
    em_dmemaddr_i  = $urandom;
    em_dmemstore_i = $urandom;
    flushed        = 1'($urandom);
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    em_d_ren_i     = 1'b0;
    em_d_wen_i     = 1'b0;
    em_halt_i      = 1'b0;
    em_dmemaddr_i  = $urandom;
    em_dmemstore_i = $urandom;
    dhit           = 1'($urandom);
    dmemload       = $urandom;
    flushed        = 1'($urandom);
    #1;
    check("idle_stall",   32'(mem_stall),   0);
    check("idle_ren",     32'(dmemREN),     0);
    check("idle_wen",     32'(dmemWEN),     0);
    check("idle_done",    32'(mem_done),    0);
    check("idle_chalt",   32'(cache_halt),  0);
    check("idle_cnt",     32'(access_cnt),  exp_cnt);
    check("idle_load",    load_data,        exp_load);
    check("idle_timeout", 32'(timeout_err), 32'(exp_to));
  endtask

  // One complete access: request cycle, k ACCESS cycles (hit on the k-th), then DONE.
  task automatic do_access(input bit ren, input bit wen, input logic [31:0] addr,
                           input logic [31:0] data, input int k,
                           input logic [31:0] rdata, input bit halt);
    bit is_wr;
    is_wr = wen;
    @(negedge CLK);
    em_d_ren_i     = ren;
    em_d_wen_i     = wen;
    em_halt_i      = halt;
    em_dmemaddr_i  = addr;
    em_dmemstore_i = data;
    dhit           = 1'b0;
    flushed        = 1'b0;
    #1;
    check("req_stall", 32'(mem_stall),  1);
    check("req_ren",   32'(dmemREN),    0);
    check("req_wen",   32'(dmemWEN),    0);
    check("req_cnt",   32'(access_cnt), exp_cnt);
    for (int j = 1; j <= k; j++) begin
      @(negedge CLK);
      drive_garbage();
      dhit     = (j == k);
      dmemload = (j == k) ? rdata : $urandom;
      #1;
      if (j - 1 >= MAX_WAIT) exp_to = 1'b1;
      check("acc_ren",     32'(dmemREN),     32'(!is_wr));
      check("acc_wen",     32'(dmemWEN),     32'(is_wr));
      check("acc_addr",    dmemaddr,         addr);
      check("acc_store",   dmemstore,        data);
      check("acc_stall",   32'(mem_stall),   1);
      check("acc_done",    32'(mem_done),    0);
      check("acc_proto",   32'(proto_err),   32'((j == 1) && ren && wen));
      check("acc_timeout", 32'(timeout_err), 32'(exp_to));
    end
    if (!is_wr) exp_load = rdata;
    @(negedge CLK);
    drive_garbage();
    dhit     = 1'($urandom);
    dmemload = $urandom;
    #1;
    check("done_pulse", 32'(mem_done),   1);
    check("done_stall", 32'(mem_stall),  0);
    check("done_ren",   32'(dmemREN),    0);
    check("done_wen",   32'(dmemWEN),    0);
    check("done_load",  load_data,       exp_load);
    check("done_proto", 32'(proto_err),  0);
    check("done_cnt",   32'(access_cnt), exp_cnt);
    if (exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no end expected end");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    int op, gap;
    RST            = 1'b1;
    em_d_ren_i     = 1'b0;
    em_d_wen_i     = 1'b0;
    em_halt_i      = 1'b0;
    em_dmemaddr_i  = '0;
    em_dmemstore_i = '0;
    dhit           = 1'b0;
    dmemload       = '0;
    flushed        = 1'b0;
    model_reset();
    #3;
    check_all_zero("rst");
    check("rst_stall", 32'(mem_stall), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Directed load with hit after 3 cycles.
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    idle_cycle();
    // Directed store with immediate hit; load_data must stay DEADBEEF.
    do_access(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 1, 32'h5555_5555, 1'b0);
    idle_cycle();
    // Back-to-back load then store.
    do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
    do_access(1'b0, 1'b1, 32'h0000_0104, 32'hA5A5_5A5A, 1, 32'h0, 1'b0);
    idle_cycle();
    // Both enables set: store wins, proto_err pulses once.
    do_access(1'b1, 1'b1, 32'h0000_0200, 32'h0BAD_0BAD, 2, 32'h7777_7777, 1'b0);

    // Randomized accesses; enough of them to saturate the 3-bit counter.
    for (int n = 0; n < 24; n++) begin
      op = $urandom_range(0, 9);
      do_access((op < 5) || (op == 9), (op >= 5), $urandom, $urandom,
                $urandom_range(1, 3), $urandom, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
    end

    // Watchdog: 6 missed ACCESS cycles before the hit.
    do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 7, 32'h1357_9BDF, 1'b0);
    check("wd_sticky", 32'(timeout_err), 1);

    // Request together with halt: access first, then flush from IDLE.
    do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1, 32'h2468_ACE0, 1'b1);
    @(negedge CLK);
    em_d_ren_i = 1'b0;
    em_d_wen_i = 1'b0;
    em_halt_i  = 1'b1;
    dhit       = 1'b0;
    flushed    = 1'b1;
    #1;
    check("halt_req_stall", 32'(mem_stall),  0);
    check("halt_req_chalt", 32'(cache_halt), 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      drive_garbage();
      dhit    = 1'($urandom);
      flushed = (i == 5);
      #1;
      check("flush_chalt",  32'(cache_halt), 1);
      check("flush_stall",  32'(mem_stall),  1);
      check("flush_halted", 32'(cpu_halted), 0);
      check("flush_ren",    32'(dmemREN),    0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive_garbage();
      dhit = 1'($urandom);
      #1;
      check("halted_flag",  32'(cpu_halted), 1);
      check("halted_chalt", 32'(cache_halt), 1);
      check("halted_stall", 32'(mem_stall),  1);
      check("halted_ren",   32'(dmemREN),    0);
      check("halted_wen",   32'(dmemWEN),    0);
    end
    @(negedge CLK);
    em_d_ren_i = 1'b0;
    em_d_wen_i = 1'b0;
    em_halt_i  = 1'b0;
    #1 RST = 1'b1;
    #1;
    check_all_zero("halt_rst");
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    idle_cycle();

    // Reset while an access is in flight, with a hit arriving in the same cycle.
    @(negedge CLK);
    em_d_ren_i    = 1'b1;
    em_d_wen_i    = 1'b0;
    em_halt_i     = 1'b0;
    em_dmemaddr_i = 32'h0000_0500;
    dhit          = 1'b0;
    #1;
    check("mid_req_stall", 32'(mem_stall), 1);
    @(negedge CLK);
    em_d_ren_i = 1'b0;
    #1;
    check("mid_acc_ren",  32'(dmemREN), 1);
    check("mid_acc_addr", dmemaddr,     32'h0000_0500);
    @(negedge CLK);
    dhit     = 1'b1;
    dmemload = 32'hFFFF_0000;
    #1 RST = 1'b1;
    #1;
    check_all_zero("mid_rst");
    check("mid_rst_stall", 32'(mem_stall), 0);
    @(negedge CLK);
    RST  = 1'b0;
    dhit = 1'b0;
    model_reset();
    idle_cycle();
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_access_ctrl

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller: the consumer of the EX/MEM pipeline latch. It takes the latched data-memory request (read, write, address, store data, halt) and runs the data-cache request/hit handshake. It stalls the pipeline until the access completes and registers load data for MEM/WB. On halt it requests a cache flush and then reports the CPU halted.

## Interface
Parameters:
- MAX_WAIT, 64: cycles in ACCESS without dhit before timeout_err sets
- CNT_W, 16: width of completed-access counter

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  asynchronous, active-high reset
- em_d_ren_i  in  1  load request from EX/MEM latch
- em_d_wen_i  in  1  store request from EX/MEM latch
- em_dmemaddr_i  in  32  word_t byte address
- em_dmemstore_i  in  32  word_t store data
- em_halt_i  in  1  halt instruction in MEM
- dhit  in  1  cache completed current access
- dmemload  in  32  word_t cache read data, valid with dhit on reads
- flushed  in  1  cache finished write-back after halt
- dmemREN  out  1  read request to cache
- dmemWEN  out  1  write request to cache
- dmemaddr  out  32  registered request address
- dmemstore  out  32  registered store data
- cache_halt  out  1  flush request to cache
- mem_stall  out  1  freezes IF/ID, ID/EX, EX/MEM latches (drives their en low)
- mem_done  out  1  one-cycle pulse, access complete
- load_data  out  32  registered read data to MEM/WB
- cpu_halted  out  1  sticky, CPU halted and cache flushed
- timeout_err  out  1  sticky watchdog flag
- proto_err  out  1  one-cycle pulse, ren and wen both set
- access_cnt  out  CNT_W  completed accesses, saturating

## Operation
- FSM states: IDLE, ACCESS, DONE, FLUSH, HALTED.
- IDLE:
  - req = em_d_ren_i | em_d_wen_i.
  - If req: capture addr/store/op into output registers, go to ACCESS.
  - If ren and wen are both set: store wins, proto_err pulses.
  - Else if em_halt_i: go to FLUSH.
  - If req and halt are both set: the access runs first; halt is taken from IDLE afterwards, because the latch still holds halt.
- ACCESS:
  - dmemREN/dmemWEN held high for the captured op; addr/store held stable.
  - Inputs are ignored; the latch is frozen.
  - On dhit: latch dmemload into load_data (reads only; writes leave load_data unchanged), drop requests, go to DONE.
- DONE:
  - mem_done=1; access_cnt increments and saturates at all-ones.
  - Go to IDLE unconditionally. The EX/MEM latch advances this cycle, so a back-to-back request is seen in IDLE the next cycle.
- FLUSH: cache_halt=1 until flushed=1, then go to HALTED.
- HALTED: cpu_halted=1 and cache_halt=1, held until RST.
- mem_stall = (IDLE & req) | ACCESS | FLUSH | HALTED.
- Watchdog:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle without dhit; it saturates.
  - Reaching MAX_WAIT sets timeout_err (sticky until RST). The FSM keeps waiting.

## Timing
- Reset (async, immediate): state IDLE. Every output is 0: dmemREN, dmemWEN, dmemaddr, dmemstore, cache_halt, mem_done, load_data, cpu_halted, timeout_err, proto_err, access_cnt. mem_stall then follows its combinational equation.
- RST mid-ACCESS: requests drop immediately, and no mem_done is produced.
- Cycle-level access:
  - Request seen in IDLE at cycle t.
  - dmemREN/WEN high from t+1.
  - dhit at cycle t+k (k≥1).
  - DONE at t+k+1, with load_data valid and mem_done high.
  - Minimum penalty is 2 stall cycles (t, t+1), and mem_stall is low in DONE.
- dhit outside ACCESS is ignored. flushed outside FLUSH is ignored.
- All outputs except mem_stall are registered or decoded from state; mem_stall is combinational from state and inputs.

## Structure
- A new shared package gets:
  - memctl_state_t enum (IDLE, ACCESS, DONE, FLUSH, HALTED)
  - mem_op_t (MEM_RD, MEM_WR)
- word_t comes from the existing CPU types package.
- Sub-module sat_counter (parameter W, inc/clr, saturating) serves both the watchdog and access_cnt.

## Test plan
- Load:
  - Stimulus: ren=1, addr=0x0000_0040; dhit after 3 cycles with dmemload=0xDEAD_BEEF.
  - Required: dmemREN high for 3 cycles; mem_stall high for 4; load_data=0xDEADBEEF and mem_done pulse in DONE; access_cnt=1.
- Store:
  - Stimulus: wen=1, addr=0x0000_0080, store=0x1234_5678; immediate dhit.
  - Required: dmemWEN 1 cycle; load_data unchanged; 2 stall cycles.
- Back-to-back load then store: two distinct mem_done pulses; access_cnt=2; no request overlap.
- ren=wen=1: proto_err pulses once, dmemWEN asserts and dmemREN stays 0.
- Halt:
  - Stimulus: em_halt_i=1; flushed after 5 cycles.
  - Required: cache_halt high from next cycle; cpu_halted=1 after flushed and sticky; RST clears both.
- Watchdog:
  - Stimulus: MAX_WAIT=4, no dhit.
  - Required: timeout_err=1 after 4 ACCESS cycles; a later dhit still completes the access.
- RST asserted mid-ACCESS: all outputs 0 at once; no mem_done.
